vmem_arbiter: RTL and testbench
===============================

VMEM_ARBITER -- requirements
Module: vmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, width of all memory addresses.
REQ-002 Parameter DATA_WIDTH, default 8, width of all memory data.
REQ-003 clk_pixel  input  1  pixel clock; all state changes on its rising edge; this is the design's one clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 vid_addr  input  ADDR_WIDTH  video-controller read address.
REQ-006 vid_rd  input  1  video read strobe, one cycle per byte.
REQ-007 vid_dout  output  DATA_WIDTH  video read data, valid the cycle after vid_rd.
REQ-008 cpu_req  input  1  CPU request valid.
REQ-009 cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-010 cpu_addr  input  ADDR_WIDTH  CPU address.
REQ-011 cpu_wdata  input  DATA_WIDTH  CPU write data.
REQ-012 cpu_ready  output  1  arbiter can accept a CPU request this cycle.
REQ-013 cpu_rdata  output  DATA_WIDTH  CPU read data; holds its value until the next read completes.
REQ-014 cpu_rvalid  output  1  single-cycle pulse: cpu_rdata updated.
REQ-015 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-016 ram_we  output  1  RAM write enable.
REQ-017 ram_wdata  output  DATA_WIDTH  RAM write data.
REQ-018 ram_rdata  input  DATA_WIDTH  synchronous RAM read data, 1-cycle latency.
REQ-019 stall_cnt  output  16  saturating count of CPU cycles blocked by video reads.

Function
REQ-020 Video reads SHALL have absolute priority: when vid_rd=1, ram_addr=vid_addr and ram_we=0 combinationally in the same cycle.
REQ-021 vid_dout SHALL equal ram_rdata combinationally, giving exactly 1-cycle read latency from vid_rd.
REQ-022 The CPU FSM SHALL have states IDLE, PEND and RDWAIT.
REQ-023 cpu_ready SHALL be 1 only in IDLE with reset deasserted.
REQ-024 A request is accepted on a clock edge with cpu_req=1 and cpu_ready=1; the edge latches cpu_addr, cpu_wdata and cpu_we into a 1-entry buffer; state goes to PEND.
REQ-025 cpu_req while cpu_ready=0 SHALL be ignored; the requester holds it until accepted.
REQ-026 In PEND with vid_rd=1: no RAM access for the CPU; state stays PEND; stall_cnt increments (saturating at 16'hFFFF).
REQ-027 In PEND with vid_rd=0: drive ram_addr from the buffer. For a write, also drive ram_we=1 and ram_wdata from the buffer, then return to IDLE. For a read, keep ram_we=0 and go to RDWAIT.
REQ-028 In RDWAIT, the edge leaving the state SHALL capture ram_rdata into cpu_rdata, set cpu_rvalid=1 for one cycle and return to IDLE.
REQ-029 A vid_rd asserted in RDWAIT SHALL be serviced normally; its data appears in the following cycle and does not corrupt the CPU capture.
REQ-030 When neither side accesses RAM: ram_we=0, ram_addr=vid_addr, ram_wdata=buffer data.
REQ-031 Throughput: at most one CPU write per 2 cycles and one CPU read per 3 cycles when video is idle.
REQ-032 With video reads at most 1 cycle in 2, a pending CPU request SHALL issue within 2 cycles.
REQ-033 A continuous vid_rd stream SHALL stall PEND indefinitely with no timeout.

Reset
REQ-034 While reset=1: state IDLE, buffer cleared, cpu_ready=0, cpu_rvalid=0, cpu_rdata=0, stall_cnt=0, ram_we=0.
REQ-035 Reset asserted mid-operation (PEND or RDWAIT) SHALL drop the pending request: no RAM write and no rvalid after release.
REQ-036 In the first cycle after reset release, cpu_ready SHALL be 1.

Verification
REQ-037 Video idle; CPU write addr 0x1234, data 0xA5 -> ram_we=1 at 0x1234 one cycle after acceptance; cpu_ready high again the next cycle.
REQ-038 RAM[0x0042]=0x3C; CPU read 0x0042, video idle -> cpu_rvalid pulses 2 cycles after acceptance with cpu_rdata=0x3C; cpu_rdata holds afterwards.
REQ-039 vid_rd held high 5 cycles while a CPU write is pending -> ram_we stays 0 for those 5 cycles; write issues on the 6th cycle; stall_cnt=5.
REQ-040 vid_rd every other cycle plus back-to-back CPU reads -> every vid_dout byte is correct the cycle after its vid_rd, and every CPU read completes correctly.
REQ-041 Reset pulsed while in PEND for a write -> no ram_we after release; cpu_ready=1 in the first cycle after release; stall_cnt=0.
REQ-042 Force stall_cnt to 16'hFFFE, then apply 3 stalled cycles -> stall_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares one synchronous RAM between a priority video reader and a buffered CPU port
module vmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    input  logic                  vid_rd,
    output logic [DATA_WIDTH-1:0] vid_dout,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [15:0]           stall_cnt
);
    typedef enum logic [1:0] {IDLE, PEND, RDWAIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [15:0]           stall_q, stall_d;
    logic                  accept;
    logic                  cpu_issue;

    // state and datapath registers; reset drops any buffered request
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            stall_q  <= stall_d;
        end
    end

    // next state: a pending request waits out every video read, then issues
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? PEND : IDLE;
            PEND:    state_d = vid_rd ? PEND : (we_q ? IDLE : RDWAIT);
            RDWAIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // request buffer, read capture, rvalid pulse and saturating stall count
    always_comb begin
        addr_d   = accept ? cpu_addr : addr_q;
        wdata_d  = accept ? cpu_wdata : wdata_q;
        we_d     = accept ? cpu_we : we_q;
        rdata_d  = (state_q == RDWAIT) ? ram_rdata : rdata_q;
        rvalid_d = (state_q == RDWAIT);
        stall_d  = (state_q == PEND && vid_rd && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    // outputs: video owns the RAM port whenever it reads; CPU only in an unstalled PEND
    always_comb begin
        cpu_ready  = (state_q == IDLE) && !reset;
        accept     = cpu_req && cpu_ready;
        cpu_issue  = (state_q == PEND) && !vid_rd;
        ram_addr   = cpu_issue ? addr_q : vid_addr;
        ram_we     = cpu_issue && we_q;
        ram_wdata  = wdata_q;
        vid_dout   = ram_rdata;
        cpu_rdata  = rdata_q;
        cpu_rvalid = rvalid_q;
        stall_cnt  = stall_q;
    end
endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: directed and randomized checks of vmem_arbiter against a RAM model and reference memory
module tb_vmem_arbiter;
    logic        clk_pixel = 1'b0;
    logic        reset;
    logic [15:0] vid_addr;
    logic        vid_rd;
    logic [7:0]  vid_dout;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [15:0] stall_cnt;

    int n_pass = 0;
    int n_total = 0;

    bit   [7:0] mem [65536];
    bit         wr  [65536];
    logic [7:0] ref_mem [int];

    vmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk_pixel(clk_pixel), .reset(reset),
        .vid_addr(vid_addr), .vid_rd(vid_rd), .vid_dout(vid_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall_cnt(stall_cnt)
    );

    always #5 clk_pixel = ~clk_pixel;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_val(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
    endfunction

    // synchronous RAM, one cycle read latency, unwritten bytes hold a fixed pattern
    always_ff @(posedge clk_pixel) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr[ram_addr]  <= 1'b1;
        end
        ram_rdata <= wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick;
        cpu_req = 1'b0;
        ref_mem[int'(a)] = d;
        tick;
    endtask

    task automatic do_read(input logic [15:0] a);
        int n;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        #1;
        n = 0;
        while (!cpu_ready && n < 8) begin tick; n++; end
        tick;
        cpu_req = 1'b0;
        #1;
        n = 0;
        while (!cpu_rvalid && n < 8) begin tick; n++; end
        chk("read_done", 32'(cpu_rvalid), 32'd1);
        chk("read_data", 32'(cpu_rdata), 32'(ref_val(a)));
        tick;
    endtask

    initial begin
        int bad;
        int lat;
        int wait_n;
        int reads_done;
        bit pend_read;
        bit acc;
        bit prev_vid;
        logic [15:0] prev_vaddr;
        logic [7:0] exp_data;

        reset = 1'b1; vid_addr = 16'h8000; vid_rd = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick; tick;
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        cpu_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("ready_after_release", 32'(cpu_ready), 32'd1);
        tick;

        // write 0x1234 <- 0xA5 with video idle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
        #1;
        chk("wr_ready", 32'(cpu_ready), 32'd1);
        tick;
        cpu_req = 1'b0;
        ref_mem[int'(16'h1234)] = 8'hA5;
        #1;
        chk("wr_we", 32'(ram_we), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'h1234);
        chk("wr_data", 32'(ram_wdata), 32'hA5);
        chk("wr_busy", 32'(cpu_ready), 32'd0);
        tick;
        chk("wr_ready_again", 32'(cpu_ready), 32'd1);
        chk("wr_we_done", 32'(ram_we), 32'd0);

        // read 0x0042 holding 0x3C: rvalid two cycles after acceptance
        do_write(16'h0042, 8'h3C);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
        tick;
        cpu_req = 1'b0;
        #1;
        chk("rd_addr", 32'(ram_addr), 32'h0042);
        chk("rd_we", 32'(ram_we), 32'd0);
        chk("rd_rvalid_c1", 32'(cpu_rvalid), 32'd0);
        tick;
        chk("rd_rvalid_c2", 32'(cpu_rvalid), 32'd0);
        chk("rd_busy_c2", 32'(cpu_ready), 32'd0);
        tick;
        chk("rd_rvalid_c3", 32'(cpu_rvalid), 32'd1);
        chk("rd_rdata_c3", 32'(cpu_rdata), 32'h3C);
        chk("rd_ready_c3", 32'(cpu_ready), 32'd1);
        tick;
        chk("rd_rvalid_c4", 32'(cpu_rvalid), 32'd0);
        chk("rd_rdata_hold", 32'(cpu_rdata), 32'h3C);
        do_read(16'h1234);

        // pending write stalled by five video reads
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h77;
        tick;
        cpu_req = 1'b0;
        vid_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vid_addr = 16'h8010 + 16'(i);
            #1;
            chk("stall_we", 32'(ram_we), 32'd0);
            chk("stall_vaddr", 32'(ram_addr), 32'(vid_addr));
            tick;
            chk("stall_vdout", 32'(vid_dout), 32'(ref_val(16'h8010 + 16'(i))));
        end
        vid_rd = 1'b0;
        #1;
        chk("stall_issue_we", 32'(ram_we), 32'd1);
        chk("stall_issue_addr", 32'(ram_addr), 32'h0100);
        chk("stall_count5", 32'(stall_cnt), 32'd5);
        ref_mem[int'(16'h0100)] = 8'h77;
        tick;
        do_read(16'h0100);

        // reset while a write is pending: write is dropped
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'hEE;
        tick;
        cpu_req = 1'b0; vid_rd = 1'b1; reset = 1'b1;
        #1;
        chk("pend_rst_we", 32'(ram_we), 32'd0);
        chk("pend_rst_ready", 32'(cpu_ready), 32'd0);
        tick;
        reset = 1'b0; vid_rd = 1'b0;
        #1;
        chk("pend_rel_ready", 32'(cpu_ready), 32'd1);
        chk("pend_rel_stall", 32'(stall_cnt), 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (ram_we) bad++;
            tick;
        end
        chk("pend_rel_no_we", 32'(bad), 32'd0);
        do_read(16'h0200);

        // reset while waiting on read data: no rvalid afterwards
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
        tick;
        cpu_req = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (cpu_rvalid) bad++;
            tick;
        end
        chk("rdwait_rst_no_rvalid", 32'(bad), 32'd0);

        // video every other cycle with back-to-back random CPU traffic
        pend_read = 0; acc = 0; prev_vid = 0; prev_vaddr = '0;
        lat = 0; wait_n = 0; reads_done = 0; exp_data = '0;
        for (int c = 0; c < 600; c++) begin
            tick;
            if (prev_vid) chk("rnd_vid_dout", 32'(vid_dout), 32'(ref_val(prev_vaddr)));
            if (pend_read) begin
                lat++;
                if (cpu_rvalid) begin
                    chk("rnd_rdata", 32'(cpu_rdata), 32'(exp_data));
                    pend_read = 0;
                    reads_done++;
                end else if (lat > 4) begin
                    chk("rnd_read_latency", 32'(lat), 32'd4);
                    pend_read = 0;
                end
            end
            if (acc) cpu_req = 1'b0;
            acc = 0;
            vid_rd = c[0];
            vid_addr = {8'h80, 8'($urandom)};
            prev_vid = vid_rd;
            prev_vaddr = vid_addr;
            if (!cpu_req && !pend_read && $urandom_range(0, 3) != 0) begin
                cpu_req = 1'b1;
                cpu_we = ($urandom_range(0, 3) == 0);
                cpu_addr = 16'($urandom_range(0, 63));
                cpu_wdata = 8'($urandom);
                wait_n = 0;
            end
            #1;
            if (cpu_req && cpu_ready) begin
                acc = 1;
                if (cpu_we) ref_mem[int'(cpu_addr)] = cpu_wdata;
                else begin
                    pend_read = 1;
                    exp_data = ref_val(cpu_addr);
                    lat = 0;
                end
            end else if (cpu_req) begin
                wait_n++;
                if (wait_n > 6) begin
                    chk("rnd_accept_wait", 32'(wait_n), 32'd6);
                    cpu_req = 1'b0;
                end
            end
        end
        tick;
        cpu_req = 1'b0; vid_rd = 1'b0;
        repeat (5) tick;
        chk("rnd_reads_done", 32'(reads_done > 20), 32'd1);

        // saturate the stall counter with a long video burst
        reset = 1'b1;
        tick;
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'h11;
        tick;
        cpu_req = 1'b0; vid_rd = 1'b1; vid_addr = 16'h8000;
        bad = 0;
        repeat (65534) begin
            tick;
            if (ram_we) bad++;
        end
        chk("sat_no_we", 32'(bad), 32'd0);
        chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
        repeat (3) tick;
        chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
        vid_rd = 1'b0;
        #1;
        chk("sat_issue_we", 32'(ram_we), 32'd1);
        chk("sat_issue_addr", 32'(ram_addr), 32'h0300);
        ref_mem[int'(16'h0300)] = 8'h11;
        tick;
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        do_read(16'h0300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
